// File: rtl/class_merge_pkg.sv
// -----------------------------------------------------------------------------
// class_merge_pkg
//   Shared definitions for the class splitter / class merge pair.
//   - merge_state_e : arbitration FSM encoding (IDLE / SERVE0 / SERVE1)
//   - class_bit()   : index of the class bit in a DATA_SIZE-bit word (the MSB)
// -----------------------------------------------------------------------------
package class_merge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE0 = 2'd1,
    SERVE1 = 2'd2
  } merge_state_e;

  // Class 0 words carry 0 in this bit, class 1 words carry 1.
  function automatic int class_bit(input int data_size);
    return data_size - 1;
  endfunction

endpackage

// File: rtl/wrr_arbiter.sv
// -----------------------------------------------------------------------------
// wrr_arbiter
//   Weighted round-robin grant FSM for the two per-class FIFOs.
//   Ports:
//     clk, reset          : clock, synchronous active-high reset
//     fifo0_empty         : FIFO 0 has no head word
//     fifo1_empty         : FIFO 1 has no head word
//     out_pause           : downstream backpressure; freezes the FSM
//     grant0, grant1      : FSM is serving FIFO 0 / FIFO 1 (one-hot or none)
//     state               : current FSM state, exposed for observation
//   A pop happens in SERVEk whenever FIFO k is non-empty and out_pause is low;
//   the top gates the actual pop strobes, this block only tracks the bursts.
// -----------------------------------------------------------------------------
module wrr_arbiter
  import class_merge_pkg::*;
#(
  parameter int W0 = 2,
  parameter int W1 = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         fifo0_empty,
  input  logic         fifo1_empty,
  input  logic         out_pause,
  output logic         grant0,
  output logic         grant1,
  output merge_state_e state
);

  localparam int WMAX = (W0 > W1) ? W0 : W1;
  localparam int BW   = $clog2(WMAX + 1);

  merge_state_e  state_nxt;
  logic [BW-1:0] burst_cnt, burst_cnt_nxt;
  logic          last_grant, last_grant_nxt;

  // Views of the FIFO being served and the other one.
  logic          serving1;
  logic          own_empty;
  logic          other_empty;
  logic [BW-1:0] limit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      burst_cnt  <= '0;
      last_grant <= 1'b1;  // FIFO 0 wins the first tie
    end else begin
      state      <= state_nxt;
      burst_cnt  <= burst_cnt_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    burst_cnt_nxt  = burst_cnt;
    last_grant_nxt = last_grant;
    serving1       = (state == SERVE1);
    own_empty      = serving1 ? fifo1_empty : fifo0_empty;
    other_empty    = serving1 ? fifo0_empty : fifo1_empty;
    limit          = serving1 ? BW'(W1 - 1) : BW'(W0 - 1);

    case (state)
      IDLE: begin
        // Both non-empty: serve the FIFO that did not have the last turn.
        if (!fifo0_empty && (fifo1_empty || last_grant)) begin
          state_nxt      = SERVE0;
          burst_cnt_nxt  = '0;
          last_grant_nxt = 1'b0;
        end else if (!fifo1_empty) begin
          state_nxt      = SERVE1;
          burst_cnt_nxt  = '0;
          last_grant_nxt = 1'b1;
        end
      end

      SERVE0, SERVE1: begin
        if (!out_pause) begin
          // A non-empty own FIFO means a pop this cycle, so reaching the
          // weight limit here ends the burst after that pop.
          if (own_empty || (burst_cnt == limit)) begin
            if (!other_empty) begin
              state_nxt      = serving1 ? SERVE0 : SERVE1;
              burst_cnt_nxt  = '0;
              last_grant_nxt = !serving1;
            end else begin
              state_nxt     = IDLE;
              burst_cnt_nxt = '0;
            end
          end else begin
            burst_cnt_nxt = burst_cnt + BW'(1);
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign grant0 = (state == SERVE0);
  assign grant1 = (state == SERVE1);

endmodule

// File: rtl/class_merge.sv
// -----------------------------------------------------------------------------
// class_merge
//   Drains the two per-class FWFT FIFOs with weighted round-robin and merges
//   them into one registered DATA_SIZE-bit stream.
//   Ports:
//     clk, reset               : clock, synchronous active-high reset
//     fifo0_data, fifo0_empty  : FIFO 0 head word / empty flag
//     fifo1_data, fifo1_empty  : FIFO 1 head word / empty flag
//     out_pause                : downstream backpressure, 1 = do not send
//     fifo0_pop, fifo1_pop     : combinational pop strobes (never both)
//     out, out_valid           : merged word and its valid (registered)
//     count0, count1           : wrapping per-class forwarded-word counters
//     class_error              : sticky, a popped word had the wrong class bit
//
//   Handshake: a FIFO's head word is taken exactly in a cycle where its pop is
//   high, which requires the FIFO to be non-empty (its "valid") and out_pause
//   low (downstream "ready"); that word appears on out with out_valid=1 in the
//   next cycle. out_valid is a one-cycle strobe per word, not held.
// -----------------------------------------------------------------------------
module class_merge
  import class_merge_pkg::*;
#(
  parameter int DATA_SIZE = 10,
  parameter int MAIN_SIZE = 8,
  parameter int W0        = 2,
  parameter int W1        = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] fifo0_data,
  input  logic                 fifo0_empty,
  input  logic [DATA_SIZE-1:0] fifo1_data,
  input  logic                 fifo1_empty,
  input  logic                 out_pause,
  output logic                 fifo0_pop,
  output logic                 fifo1_pop,
  output logic [DATA_SIZE-1:0] out,
  output logic                 out_valid,
  output logic [MAIN_SIZE-1:0] count0,
  output logic [MAIN_SIZE-1:0] count1,
  output logic                 class_error
);

  localparam int CB = class_bit(DATA_SIZE);

  logic                 grant0, grant1;
  merge_state_e         arb_state;
  logic [DATA_SIZE-1:0] pop_data;

  wrr_arbiter #(
    .W0 (W0),
    .W1 (W1)
  ) u_arb (
    .clk         (clk),
    .reset       (reset),
    .fifo0_empty (fifo0_empty),
    .fifo1_empty (fifo1_empty),
    .out_pause   (out_pause),
    .grant0      (grant0),
    .grant1      (grant1),
    .state       (arb_state)
  );

  // Reset is folded in so a reset cycle can never consume a FIFO word.
  assign fifo0_pop = grant0 & !fifo0_empty & !out_pause & !reset;
  assign fifo1_pop = grant1 & !fifo1_empty & !out_pause & !reset;

  assign pop_data = (arb_state == SERVE1) ? fifo1_data : fifo0_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      out         <= '0;
      out_valid   <= 1'b0;
      count0      <= '0;
      count1      <= '0;
      class_error <= 1'b0;
    end else begin
      out_valid <= fifo0_pop | fifo1_pop;
      if (fifo0_pop | fifo1_pop) begin
        out <= pop_data;
      end
      if (fifo0_pop) begin
        count0 <= count0 + MAIN_SIZE'(1);
        if (fifo0_data[CB]) class_error <= 1'b1;
      end
      if (fifo1_pop) begin
        count1 <= count1 + MAIN_SIZE'(1);
        if (!fifo1_data[CB]) class_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_class_merge.sv
// -----------------------------------------------------------------------------
// tb_class_merge
//   Directed and randomized bench for class_merge. FIFO contents live in
//   queues; the expected output order is derived from the weighted
//   round-robin rule (alternate turns, each taking up to Wk words).
// -----------------------------------------------------------------------------
module tb_class_merge;

  localparam int DATA_SIZE = 10;
  localparam int MAIN_SIZE = 8;
  localparam int W0        = 2;
  localparam int W1        = 2;

  logic                 clk;
  logic                 reset;
  logic [DATA_SIZE-1:0] fifo0_data, fifo1_data;
  logic                 fifo0_empty, fifo1_empty;
  logic                 out_pause;
  logic                 fifo0_pop, fifo1_pop;
  logic [DATA_SIZE-1:0] out;
  logic                 out_valid;
  logic [MAIN_SIZE-1:0] count0, count1;
  logic                 class_error;

  class_merge #(
    .DATA_SIZE (DATA_SIZE),
    .MAIN_SIZE (MAIN_SIZE),
    .W0        (W0),
    .W1        (W1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .fifo0_data  (fifo0_data),
    .fifo0_empty (fifo0_empty),
    .fifo1_data  (fifo1_data),
    .fifo1_empty (fifo1_empty),
    .out_pause   (out_pause),
    .fifo0_pop   (fifo0_pop),
    .fifo1_pop   (fifo1_pop),
    .out         (out),
    .out_valid   (out_valid),
    .count0      (count0),
    .count1      (count1),
    .class_error (class_error)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- bench state ----------------
  logic [DATA_SIZE-1:0] q0[$];
  logic [DATA_SIZE-1:0] q1[$];
  logic [DATA_SIZE-1:0] exp_q[$];
  logic                 exp_src[$];
  logic [MAIN_SIZE-1:0] exp_c0, exp_c1;
  logic                 exp_err;
  logic                 drv_reset, drv_pause;
  logic                 last_p0, last_p1, first_src;
  int                   n_checks, n_pass, n_fail;
  int                   cyc, first_out, last_out, n_pop0, n_pop1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_SIZE-1:0] rand_word(input logic cls);
    logic [DATA_SIZE-1:0] w;
    w = DATA_SIZE'($urandom_range(0, (1 << (DATA_SIZE - 1)) - 1));
    w[DATA_SIZE-1] = cls;
    return w;
  endfunction

  // Reference order: starting with FIFO 0 (after reset), turns alternate and
  // each turn takes up to Wk words from its FIFO.
  task automatic build_expected();
    logic [DATA_SIZE-1:0] a[$];
    logic [DATA_SIZE-1:0] b[$];
    int turn;
    a = q0;
    b = q1;
    exp_q.delete();
    exp_src.delete();
    turn = 0;
    while (a.size() + b.size() > 0) begin
      if (turn == 0) begin
        for (int k = 0; k < W0 && a.size() > 0; k++) begin
          exp_q.push_back(a.pop_front());
          exp_src.push_back(1'b0);
        end
      end else begin
        for (int k = 0; k < W1 && b.size() > 0; k++) begin
          exp_q.push_back(b.pop_front());
          exp_src.push_back(1'b1);
        end
      end
      turn = 1 - turn;
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic tick();
    logic p0, p1, was_reset, s;
    logic [DATA_SIZE-1:0] w;
    @(negedge clk);
    reset       = drv_reset;
    out_pause   = drv_pause;
    fifo0_empty = (q0.size() == 0);
    fifo1_empty = (q1.size() == 0);
    fifo0_data  = '0;
    fifo1_data  = '0;
    if (q0.size() > 0) fifo0_data = q0[0];
    if (q1.size() > 0) fifo1_data = q1[0];
    #1;
    p0 = fifo0_pop;
    p1 = fifo1_pop;
    last_p0 = p0;
    last_p1 = p1;
    if (p0) n_pop0++;
    if (p1) n_pop1++;
    check("pop_legal", 32'({p0 & (fifo0_empty | out_pause | reset),
                            p1 & (fifo1_empty | out_pause | reset),
                            p0 & p1}), 32'd0);
    was_reset = reset;
    @(posedge clk);
    #1;
    if (p0 && q0.size() > 0) void'(q0.pop_front());
    if (p1 && q1.size() > 0) void'(q1.pop_front());
    cyc++;
    // ---------------- scoreboard ----------------
    if (was_reset) begin
      exp_c0  = '0;
      exp_c1  = '0;
      exp_err = 1'b0;
      check("rst_out", 32'(out), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
    end else begin
      check("out_valid", 32'(out_valid), 32'(p0 | p1));
      if (p0 | p1) begin
        check("scoreboard_has_word", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          w = exp_q.pop_front();
          s = exp_src.pop_front();
          check("out_word", 32'(out), 32'(w));
          if (s) exp_c1 = exp_c1 + 8'd1;
          else   exp_c0 = exp_c0 + 8'd1;
          if (w[DATA_SIZE-1] != s) exp_err = 1'b1;
          if (first_out < 0) begin
            first_out = cyc;
            first_src = p1;
          end
          last_out = cyc;
        end
      end
    end
    check("count0", 32'(count0), 32'(exp_c0));
    check("count1", 32'(count1), 32'(exp_c1));
    check("class_error", 32'(class_error), 32'(exp_err));
  endtask

  task automatic start_test();
    drv_reset = 1'b1;
    drv_pause = 1'b0;
    tick();
    drv_reset = 1'b0;
    build_expected();
    cyc       = 0;
    first_out = -1;
    last_out  = -1;
    n_pop0    = 0;
    n_pop1    = 0;
  endtask

  task automatic drain(input int budget, input int pause_pct);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      drv_pause = ($urandom_range(0, 99) < pause_pct);
      tick();
      n++;
    end
    drv_pause = 1'b0;
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (3) tick();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    n_checks = 0; n_pass = 0; n_fail = 0;
    exp_c0 = '0; exp_c1 = '0; exp_err = 1'b0;
    cyc = 0; first_out = -1; last_out = -1; n_pop0 = 0; n_pop1 = 0;
    last_p0 = 1'b0; last_p1 = 1'b0; first_src = 1'b0;
    drv_reset = 1'b1; drv_pause = 1'b0;
    reset = 1'b1; out_pause = 1'b0;
    fifo0_empty = 1'b1; fifo1_empty = 1'b1;
    fifo0_data = '0; fifo1_data = '0;

    // Reset state with empty FIFOs
    tick();
    tick();
    drv_reset = 1'b0;
    repeat (2) tick();

    // Single word through FIFO 0
    q0 = {10'h0FF};
    start_test();
    drain(50, 0);
    check("t1_first_out_cycle", 32'(first_out), 32'd2);
    check("t1_pop0_count", 32'(n_pop0), 32'd1);
    check("t1_count0", 32'(count0), 32'd1);
    check("t1_class_error", 32'(class_error), 32'd0);

    // Interleaved bursts of two, one bubble at start only
    q0 = {10'h0FF, 10'h0EE, 10'h0BB, 10'h0AA};
    q1 = {10'h3DD, 10'h3CC, 10'h399, 10'h388};
    start_test();
    drain(100, 0);
    check("t2_first_out_cycle", 32'(first_out), 32'd2);
    check("t2_span", 32'(last_out - first_out), 32'd7);
    check("t2_count0", 32'(count0), 32'd4);
    check("t2_count1", 32'(count1), 32'd4);

    // Same loading, three paused cycles after the second pop
    q0 = {10'h0FF, 10'h0EE, 10'h0BB, 10'h0AA};
    q1 = {10'h3DD, 10'h3CC, 10'h399, 10'h388};
    start_test();
    repeat (3) tick();
    drv_pause = 1'b1;
    repeat (3) begin
      tick();
      check("t3_paused_out_valid", 32'(out_valid), 32'd0);
    end
    drv_pause = 1'b0;
    drain(100, 0);
    check("t3_span", 32'(last_out - first_out), 32'd10);
    check("t3_count0", 32'(count0), 32'd4);
    check("t3_count1", 32'(count1), 32'd4);

    // FIFO 1 only: bursts of two separated by an IDLE bubble
    q1 = {10'h3DD, 10'h3CC, 10'h399, 10'h388, 10'h377};
    start_test();
    drain(100, 0);
    check("t4_first_out_cycle", 32'(first_out), 32'd2);
    check("t4_span", 32'(last_out - first_out), 32'd6);
    check("t4_count1", 32'(count1), 32'd5);

    // Misclassified word: forwarded, sticky error until reset
    q0 = {10'h3DD};
    start_test();
    drain(50, 0);
    check("t5_error_set", 32'(class_error), 32'd1);
    repeat (4) tick();
    check("t5_error_sticky", 32'(class_error), 32'd1);
    start_test();
    check("t5_error_cleared", 32'(class_error), 32'd0);

    // Reset after the first pop of a FIFO 0 burst
    q0 = {10'h0FF, 10'h0EE, 10'h0BB, 10'h0AA};
    q1 = {10'h3DD, 10'h3CC};
    start_test();
    repeat (2) tick();
    drv_reset = 1'b1;
    tick();
    check("t6_no_pop_in_reset", 32'({last_p0, last_p1}), 32'd0);
    check("t6_counts_cleared", 32'({count0, count1}), 32'd0);
    drv_reset = 1'b0;
    build_expected();
    cyc = 0; first_out = -1; last_out = -1;
    drain(100, 0);
    check("t6_first_src_fifo0", 32'(first_src), 32'd0);
    check("t6_first_out_cycle", 32'(first_out), 32'd2);

    // Counter wrap: 300 class-0 words
    for (int i = 0; i < 300; i++) q0.push_back(rand_word(1'b0));
    start_test();
    drain(1000, 0);
    check("t7_count0_wrap", 32'(count0), 32'd44);

    // Randomized loads with random backpressure
    for (int it = 0; it < 12; it++) begin
      int n0, n1;
      n0 = $urandom_range(0, 8);
      n1 = $urandom_range(0, 8);
      q0.delete();
      q1.delete();
      for (int i = 0; i < n0; i++) q0.push_back(rand_word($urandom_range(0, 7) == 0));
      for (int i = 0; i < n1; i++) q1.push_back(rand_word($urandom_range(0, 7) != 0));
      start_test();
      drain(400, 30);
      check("rand_all_popped", 32'(q0.size() + q1.size()), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/class_merge.md
Name: class_merge

Overview:
- Egress-side counterpart of the class splitter. Drains the two per-class FIFOs (class 0 = data[DATA_SIZE-1]==0, class 1 = data[DATA_SIZE-1]==1) and merges them back into one DATA_SIZE-bit stream.
- Arbitration is weighted round-robin, and output is throttled by the downstream pause signal.
- Sits between the FIFO pair and the next switch stage.

Parameters:
- DATA_SIZE, 10, word width; MSB is the class bit.
- MAIN_SIZE, 8, width of the per-class grant counters.
- W0, 2, maximum consecutive pops from FIFO 0 per turn (>=1).
- W1, 2, maximum consecutive pops from FIFO 1 per turn (>=1).

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- fifo0_data  in  DATA_SIZE  head word of FIFO 0 (first-word-fall-through; valid whenever !fifo0_empty).
- fifo0_empty  in  1  FIFO 0 empty.
- fifo1_data  in  DATA_SIZE  head word of FIFO 1 (FWFT).
- fifo1_empty  in  1  FIFO 1 empty.
- out_pause  in  1  downstream backpressure; 1 = do not send.
- fifo0_pop  out  1  pop FIFO 0 this cycle (combinational).
- fifo1_pop  out  1  pop FIFO 1 this cycle (combinational).
- out  out  DATA_SIZE  merged data (registered).
- out_valid  out  1  out holds a new word this cycle (registered).
- count0  out  MAIN_SIZE  words forwarded from FIFO 0; wraps.
- count1  out  MAIN_SIZE  words forwarded from FIFO 1; wraps.
- class_error  out  1  sticky flag: a popped word's class bit does not match its FIFO.

Behaviour:
- Reset (reset==1 at a posedge):
  - All outputs go to 0: out=0, out_valid=0, counts=0, class_error=0.
  - state=IDLE, burst_cnt=0, last_grant=1, so FIFO 0 wins the first tie.
  - Reset mid-burst aborts the burst. No pop is asserted in any cycle where reset==1.
- FSM states: IDLE, SERVE0, SERVE1.
- Pop equations:
  - fifo0_pop = (state==SERVE0) & !fifo0_empty & !out_pause & !reset.
  - fifo1_pop is the same with SERVE1 and fifo1_empty.
  - Pops are never asserted in IDLE.
- Data path:
  - On a posedge with fifoK_pop=1: out<=fifoK_data, out_valid<=1, countK<=countK+1 (mod 2^MAIN_SIZE), burst_cnt<=burst_cnt+1.
  - On any posedge with no pop: out_valid<=0 and out holds its value.
  - Latency: pop cycle N gives out_valid in cycle N+1.
- class_error: set when FIFO 0 pops a word with MSB==1, or FIFO 1 pops a word with MSB==0. The word is still forwarded. The flag is cleared only by reset.
- IDLE transitions:
  - Both FIFOs empty: stay in IDLE.
  - Exactly one non-empty: go to SERVEk.
  - Both non-empty: go to the FIFO != last_grant.
  - On entering SERVEk: burst_cnt<=0, last_grant<=k.
  - IDLE costs one bubble cycle.
- SERVEk transitions, evaluated on each posedge (pause has priority):
  - out_pause==1: state, burst_cnt and last_grant frozen.
  - The burst ends when a pop occurs with burst_cnt==Wk-1, or when fifoK_empty==1.
  - At burst end:
    - Other FIFO non-empty: go directly to SERVEother (no bubble), burst_cnt<=0, last_grant<=other.
    - Else own FIFO non-empty after this pop (fifoK_empty deasserts next cycle): go to IDLE (re-arbitration picks k again).
    - Else: go to IDLE.
- Simultaneous pops are impossible by construction; at most one pop per cycle.
- out_pause rising while out_valid=1: the already-registered word completes (out_valid drops next cycle). No pop occurs in a paused cycle.
- Counters wrap from 2^MAIN_SIZE-1 to 0 silently.

Decomposition:
- Shared package: FSM state encoding (IDLE/SERVE0/SERVE1) and the class-bit index constant (DATA_SIZE-1), also used by the splitter.
- Sub-module wrr_arbiter: FSM, burst_cnt and last_grant. Outputs grant0/grant1.
- class_merge top holds the pop gating, output register, counters and class_error.

Test Plan:
- Reset then single word 10'h0FF in FIFO 0 -> IDLE, then SERVE0; fifo0_pop for 1 cycle; next cycle out=0FF, out_valid=1; count0=1; class_error=0.
- FIFO 0 = {0FF,0EE,0BB,0AA}, FIFO 1 = {3DD,3CC,399,388}, W0=W1=2, no pause -> out sequence 0FF,0EE,3DD,3CC,0BB,0AA,399,388; one bubble only at start; count0=count1=4.
- Same loading, out_pause=1 for 3 cycles after the second pop -> no pops and out_valid=0 during the pause; sequence resumes unchanged with no word lost or duplicated.
- FIFO 1 only = {3DD,3CC,399,388,377}, W1=2 -> pops in bursts of 2 with an IDLE bubble between bursts; all 5 words output; count1=5.
- Word 10'h3DD placed in FIFO 0 -> forwarded as 3DD and class_error=1; flag stays 1 until reset, then reads 0.
- Reset asserted mid-burst (after 1 of 2 pops) -> no pop that cycle; out_valid=0, counts=0 next cycle; after release FIFO 0 is served first.
